// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : SPI mode-0 slave receiver. Oversamples sclk/ss/mosi in the
//               clk domain, shifts mosi MSB-first on rising sclk while ss is
//               low, and presents each completed word with a one-clk strobe.
// Ports       : clk       - system clock (rising edge)
//               rst       - asynchronous active-low reset
//               sclk      - SPI clock from master, idle low
//               ss        - slave select, active low
//               mosi      - serial data, MSB first
//               rx_data   - last complete word, held until the next one
//               rx_valid  - one-clk pulse when rx_data updates
//               frame_err - one-clk pulse when ss rises on a partial word
//               busy      - high while a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [2:0]      FLUSH    = 3'(SYNC_STAGES + 1);
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_SHIFT = 1'b1;

    // ------------------------------------------------------------------
    // Synchronisers plus one history flop on sclk and ss
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_hist_q;
    logic                   ss_hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    logic w_sync_sclk, w_sync_ss, w_sync_mosi;
    logic w_rise_sclk, w_ss_fall, w_ss_rise;

    assign w_sync_sclk = sclk_sync_q[SYNC_STAGES-1];
    assign w_sync_ss   = ss_sync_q[SYNC_STAGES-1];
    assign w_sync_mosi = mosi_sync_q[SYNC_STAGES-1];
    assign w_rise_sclk = w_sync_sclk & ~sclk_hist_q;
    assign w_ss_fall   = ~w_sync_ss & ss_hist_q;
    assign w_ss_rise   = w_sync_ss & ~ss_hist_q;

    // ------------------------------------------------------------------
    // Receive state
    // ------------------------------------------------------------------
    logic [0:0]            state_q,     state_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  done_q,      done_d;
    logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [2:0]            flush_q,     flush_d;
    logic                  armed_q,     armed_d;
    logic                  w_last_rise;

    assign w_last_rise = w_rise_sclk && (cnt_q == LAST_BIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        flush_d     = flush_q;
        armed_d     = armed_q;

        // The ss synchroniser resets to "deselected"; if ss is low when
        // reset is released the chain produces a false falling edge. Only
        // accept a frame start once the chain holds real samples and ss
        // has actually been seen high.
        if (flush_q != FLUSH) begin
            flush_d = flush_q + 3'd1;
        end else if (w_sync_ss) begin
            armed_d = 1'b1;
        end

        // Word completion is pipelined one cycle behind the last shift so
        // it still retires when ss rises in the same cycle.
        if (done_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_ss_fall && armed_q) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (w_rise_sclk) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], w_sync_mosi};
                    if (w_last_rise) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (w_ss_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!w_last_rise && (cnt_q != '0)) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx
// Description : Self-checking bench for spi_slave_rx (table-driven frames
//               plus hand-written corner-case sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

    localparam int DW  = 12;
    localparam int LAT = 4;   // SYNC_STAGES + 2

    logic          clk;
    logic          rst;
    logic          sclk;
    logic          ss;
    logic          mosi;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    int          last_rise_cyc = 0;
    int          last_lat = -1;
    int          bad_pulse = 0;
    logic [DW-1:0] data_q[$];
    int          valid_cyc[$];
    logic        prev_valid = 1'b0;
    logic        prev_err   = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            data_q.push_back(rx_data);
            valid_cyc.push_back(cyc);
            last_lat = cyc - last_rise_cyc;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if ((rx_valid && frame_err) || (rx_valid && prev_valid) || (frame_err && prev_err))
            bad_pulse = bad_pulse + 1;
        prev_valid = rx_valid;
        prev_err   = frame_err;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        err_cnt   = 0;
        last_lat  = -1;
        data_q.delete();
        valid_cyc.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: data set at start of the low phase, 10 clk low, 10 high.
    task automatic send_bit(input logic b);
        mosi = b;
        wait_clk(10);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        wait_clk(10);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[DW-1-i]);
    endtask

    task automatic run_frame(input logic [DW-1:0] w, input int nbits, input string tag);
        ss = 1'b0;
        wait_clk(10);
        chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
        send_bits(w, nbits);
        wait_clk(5);
        ss = 1'b1;
        wait_clk(10);
        chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] word;
        int            nbits;
        int            exp_valid;
        int            exp_err;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [DW-1:0] w;

        vecs[0] = '{word: 12'h800, nbits: 5,  exp_valid: 0, exp_err: 1, exp_data: 12'h000};
        vecs[1] = '{word: 12'hA5C, nbits: 12, exp_valid: 1, exp_err: 0, exp_data: 12'hA5C};
        vecs[2] = '{word: 12'h3C3, nbits: 12, exp_valid: 1, exp_err: 0, exp_data: 12'h3C3};
        vecs[3] = '{word: 12'h123, nbits: 11, exp_valid: 0, exp_err: 1, exp_data: 12'h3C3};
        vecs[4] = '{word: 12'h001, nbits: 12, exp_valid: 1, exp_err: 0, exp_data: 12'h001};
        vecs[5] = '{word: 12'hFFF, nbits: 12, exp_valid: 1, exp_err: 0, exp_data: 12'hFFF};

        rst  = 1'b0;
        ss   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(3);
        chk("reset_rx_data",   {20'd0, rx_data},     32'd0);
        chk("reset_rx_valid",  {31'd0, rx_valid},    32'd0);
        chk("reset_frame_err", {31'd0, frame_err},   32'd0);
        chk("reset_busy",      {31'd0, busy},        32'd0);
        rst = 1'b1;
        wait_clk(10);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            run_frame(vecs[i].word, vecs[i].nbits, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_valid_cnt", i), valid_cnt, vecs[i].exp_valid);
            chk($sformatf("vec%0d_err_cnt", i),   err_cnt,   vecs[i].exp_err);
            chk($sformatf("vec%0d_rx_data", i),   {20'd0, rx_data}, {20'd0, vecs[i].exp_data});
            if (vecs[i].exp_valid == 1)
                chk($sformatf("vec%0d_latency", i), last_lat, LAT);
        end

        // ---------------- two words in one frame ----------------
        clear_mon();
        ss = 1'b0;
        wait_clk(10);
        send_bits(12'hFFF, 12);
        send_bits(12'h001, 12);
        wait_clk(5);
        ss = 1'b1;
        wait_clk(10);
        chk("two_valid_cnt", valid_cnt, 2);
        chk("two_err_cnt",   err_cnt,   0);
        if (data_q.size() == 2) begin
            chk("two_word0", {20'd0, data_q[0]}, 32'h0FFF);
            chk("two_word1", {20'd0, data_q[1]}, 32'h0001);
            chk("two_gap_ge20", {31'd0, (valid_cyc[1] - valid_cyc[0]) >= 20}, 32'd1);
        end else begin
            chk("two_words_present", data_q.size(), 2);
        end

        // ---------------- sclk toggles with ss high ----------------
        clear_mon();
        send_bits(12'hFFF, 12);
        chk("ss_high_valid", valid_cnt, 0);
        chk("ss_high_busy",  {31'd0, busy}, 32'd0);
        run_frame(12'h3C3, 12, "after_ss_high");
        chk("after_ss_high_valid", valid_cnt, 1);
        chk("after_ss_high_data",  {20'd0, rx_data}, 32'h03C3);
        chk("after_ss_high_err",   err_cnt, 0);

        // ---------------- reset mid-frame ----------------
        clear_mon();
        ss = 1'b0;
        wait_clk(10);
        send_bits(12'h155, 6);
        rst = 1'b0;
        #1;
        chk("midrst_rx_data", {20'd0, rx_data}, 32'd0);
        chk("midrst_busy",    {31'd0, busy},    32'd0);
        wait_clk(3);
        rst = 1'b1;
        wait_clk(10);
        w = 12'hFFF;
        send_bits(w, 12);
        wait_clk(5);
        chk("midrst_no_capture", valid_cnt, 0);
        chk("midrst_no_err",     err_cnt,   0);
        chk("midrst_idle",       {31'd0, busy}, 32'd0);
        ss = 1'b1;
        wait_clk(10);
        run_frame(12'h155, 12, "post_rst");
        chk("post_rst_valid", valid_cnt, 1);
        chk("post_rst_data",  {20'd0, rx_data}, 32'h0155);

        // ---------------- ss rise coincident with last sclk rise ----------------
        clear_mon();
        w = 12'h6B9;
        ss = 1'b0;
        wait_clk(10);
        send_bits(w, 11);
        mosi = w[0];
        wait_clk(10);
        sclk = 1'b1;
        ss   = 1'b1;
        last_rise_cyc = cyc;
        wait_clk(10);
        sclk = 1'b0;
        wait_clk(10);
        chk("coinc_valid",   valid_cnt, 1);
        chk("coinc_err",     err_cnt,   0);
        chk("coinc_data",    {20'd0, rx_data}, 32'h06B9);
        chk("coinc_latency", last_lat, LAT);
        chk("coinc_busy",    {31'd0, busy}, 32'd0);

        chk("pulse_shape", bad_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI slave-side receiver: the far end of the team's SPI master MOSI transmitter.
- Samples `mosi` while `ss` is low, shifting MSB-first on rising `sclk` edges (mode 0).
- Presents each completed word to local logic on `rx_data` with a one-cycle `rx_valid` strobe.
- `sclk`, `ss` and `mosi` are asynchronous to `clk`. They are synchronised and oversampled in the `clk` domain.

Parameters:
- DATA_WIDTH, 12: bits per SPI word; legal range 2..32.
- SYNC_STAGES, 2: synchroniser flops on `sclk`/`ss`/`mosi`; legal range 2..3.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI serial clock from master, idle low.
- ss  input  1  slave select, active low.
- mosi  input  1  serial data from master, MSB first.
- rx_data  output  DATA_WIDTH  last complete word; held until the next word completes.
- rx_valid  output  1  one-clk pulse when `rx_data` updates.
- frame_err  output  1  one-clk pulse when `ss` rises with a partial word.
- busy  output  1  high while a frame is in progress (synchronised `ss` low).

Behaviour:
- Reset: `rst`=0 asynchronously clears all state.
  - Outputs: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.
  - Internal: shift register = 0, bit counter = 0, FSM = IDLE.
  - Synchroniser flops reset to `sclk`=0, `ss`=1, `mosi`=0.
- Synchronisation:
  - `sclk`, `ss` and `mosi` each pass through SYNC_STAGES flops, plus one extra history flop on `sclk` and `ss`.
  - rise_sclk = sync_sclk & ~hist_sclk. ss_fall and ss_rise are defined the same way.
  - `mosi` uses the same depth as `sclk`, so the sampled bit is aligned with the detected edge.
- Master timing requirement: `sclk` high and low phases ≥ SYNC_STAGES+2 clk each. `mosi` is stable from ≥ 2 clk before to ≥ 2 clk after each rising `sclk`.
- FSM:
  - IDLE: wait for ss_fall, then clear bit counter and go to SHIFT. `busy`=1 from the cycle after ss_fall is detected.
  - SHIFT: on each rise_sclk, shift_reg <= {shift_reg[DATA_WIDTH-2:0], sync_mosi} and increment the counter.
  - SHIFT, last bit: when the counter reaches DATA_WIDTH-1 and rise_sclk occurs, the next cycle loads `rx_data` with the full word, pulses `rx_valid`, and resets the counter to 0. The FSM stays in SHIFT, so back-to-back words within one `ss` frame are supported.
  - SHIFT, ss_rise: go to IDLE. If the counter ≠ 0, pulse `frame_err` and discard the partial word; `rx_data` is unchanged.
- `sclk` edges seen while synchronised `ss`=1 are ignored.
- Simultaneous ss_rise and last-bit rise_sclk in the same cycle: the word completes (`rx_valid` pulse), there is no `frame_err`, and the FSM goes to IDLE.
- Latency: `rx_valid` rises SYNC_STAGES+2 clk after the final raw `sclk` rising edge.
- `rx_valid` and `frame_err` are never high in the same cycle, and neither is ever high for more than one clk.
- Reset asserted mid-frame: the partial word is lost with no error pulse. After `rst` is released with `ss` still low, the receiver waits in IDLE for a fresh ss_fall.

Test Plan:
- Reset, then `ss` low and the master sends 12'hA5C MSB-first, `sclk` = clk/20 → exactly one `rx_valid` pulse, `rx_data`=12'hA5C, `frame_err` never high, `busy` high from `ss` fall to `ss` rise.
- Two words 12'hFFF then 12'h001 in one `ss` frame → two `rx_valid` pulses ≥ 20 clk apart; `rx_data` reads 12'hFFF then 12'h001.
- `ss` rises after 5 bits of 12'h800 → one `frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value (0 after reset).
- `sclk` toggled 12 times with `ss` high, then a normal frame with 12'h3C3 → nothing is received during the `ss`-high toggles; only 12'h3C3 appears.
- `rst` pulsed low after 6 bits with `ss` held low → outputs immediately 0. No capture occurs until `ss` goes high then low; the next frame with 12'h155 yields `rx_data`=12'h155.
- Final `sclk` rise timed so its detected edge coincides with ss_rise → `rx_valid` with the correct word, `frame_err`=0.
